// File: rtl/hex_scan_ctrl_if.sv
// Display-side bus of the 4-digit multiplexed hex scanner.
//   load        : one-cycle strobe that captures data/blank_mask/lz_en
//   data        : four hex nibbles, digit 0 in data[3:0]
//   blank_mask  : bit i forces digit i blank
//   lz_en       : leading-zero suppression enable
//   seg         : active-low segments, seg[6]=a .. seg[0]=g
//   an          : active-low digit enables
//   frame_start : one-cycle pulse when the digit 0 slot begins
// master = the producer of display content, slave = the scanner.
interface hex_scan_ctrl_if;
   logic        load;
   logic [15:0] data;
   logic [3:0]  blank_mask;
   logic        lz_en;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_start;

   modport master (
      output load, data, blank_mask, lz_en,
      input  seg, an, frame_start
   );

   modport slave (
      input  load, data, blank_mask, lz_en,
      output seg, an, frame_start
   );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Four-digit multiplexed 7-segment hex scanner.
// Each digit gets a DEAD slot (all digits off, DEAD_CYC cycles) followed by a
// DRIVE slot (that digit on, TICK_DIV cycles); digits are visited 0,1,2,3.
// New content is captured into a pending shadow on load and only copied into
// the active set when digit 3 wraps back to digit 0, so a frame never tears.
// Ports:
//   clk : clock, all state changes on its rising edge
//   rst : asynchronous active-high reset
//   bus : hex_scan_ctrl_if.slave (load/data/blank_mask/lz_en in,
//         seg/an/frame_start out, all outputs registered)
module hex_scan_ctrl #(
   parameter int TICK_DIV = 50000,
   parameter int DEAD_CYC = 4
) (
   input  logic            clk,
   input  logic            rst,
   hex_scan_ctrl_if.slave  bus
);

   localparam int MAX_CYC = (TICK_DIV > DEAD_CYC) ? TICK_DIV : DEAD_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);

   typedef enum logic {DEAD, DRIVE} state_t;

   state_t           state;
   logic [1:0]       digit;
   logic [CNT_W-1:0] cnt;

   logic [15:0] act_data, pnd_data;
   logic [3:0]  act_mask, pnd_mask;
   logic        act_lz, pnd_lz, pnd_vld;

   logic [6:0]  seg_r;
   logic [3:0]  an_r;
   logic        fs_r;

   logic [3:0]  nib;
   logic [6:0]  drive_seg;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // Digit i is blank when masked, or when suppression is on and it and every
   // more-significant nibble are zero. Digit 0 always shows something.
   function automatic logic digit_blank(input logic [15:0] d, input logic [3:0] m,
                                        input logic lz, input logic [1:0] i);
      logic zero_above;
      case (i)
         2'd1:    zero_above = (d[15:4]  == 12'h000);
         2'd2:    zero_above = (d[15:8]  == 8'h00);
         2'd3:    zero_above = (d[15:12] == 4'h0);
         default: zero_above = 1'b0;
      endcase
      return m[i] | (lz & zero_above);
   endfunction

   // Single shared decoder, fed from registered state only (active set and
   // digit index), so no input reaches an output without a register between.
   always_comb begin
      nib       = act_data[{digit, 2'b00} +: 4];
      drive_seg = digit_blank(act_data, act_mask, act_lz, digit) ? 7'h7F : hex_to_seg(nib);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= DEAD;
         digit    <= 2'd0;
         cnt      <= '0;
         act_data <= 16'h0000;
         act_mask <= 4'h0;
         act_lz   <= 1'b0;
         pnd_data <= 16'h0000;
         pnd_mask <= 4'h0;
         pnd_lz   <= 1'b0;
         pnd_vld  <= 1'b0;
         seg_r    <= 7'h7F;
         an_r     <= 4'hF;
         fs_r     <= 1'b0;
      end else begin
         fs_r <= 1'b0;
         case (state)
            DEAD: begin
               if (cnt == DEAD_LAST) begin
                  state <= DRIVE;
                  cnt   <= '0;
                  an_r  <= ~(4'b0001 << digit);
                  seg_r <= drive_seg;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRIVE: begin
               if (cnt == TICK_LAST) begin
                  state <= DEAD;
                  cnt   <= '0;
                  digit <= digit + 2'd1;
                  an_r  <= 4'hF;
                  seg_r <= 7'h7F;
                  // 3 -> 0 wrap: frame boundary, the only point content may change
                  if (digit == 2'd3) begin
                     fs_r <= 1'b1;
                     if (pnd_vld) begin
                        act_data <= pnd_data;
                        act_mask <= pnd_mask;
                        act_lz   <= pnd_lz;
                        pnd_vld  <= 1'b0;
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= DEAD;
         endcase
         // Placed after the wrap so a load on the wrap edge stays pending.
         if (bus.load) begin
            pnd_data <= bus.data;
            pnd_mask <= bus.blank_mask;
            pnd_lz   <= bus.lz_en;
            pnd_vld  <= 1'b1;
         end
      end
   end

   assign bus.seg         = seg_r;
   assign bus.an          = an_r;
   assign bus.frame_start = fs_r;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
module tb_hex_scan_ctrl;
   localparam int TD    = 4;
   localparam int DC    = 2;
   localparam int SLOT  = TD + DC;
   localparam int FRAME = 4 * SLOT;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       fs;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   hex_scan_ctrl_if bus ();

   hex_scan_ctrl #(.TICK_DIV(TD), .DEAD_CYC(DC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   exp_t sb_q[$];

   logic [6:0] segtab [16];

   // reference model state
   int          t = 0;
   logic [15:0] m_act_d, m_pnd_d;
   logic [3:0]  m_act_m, m_pnd_m;
   logic        m_act_lz, m_pnd_lz, m_pv;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
      end
   endtask

   function automatic exp_t expect_now();
      exp_t e;
      int pos, slot, ph;
      logic [3:0] n;
      logic blank;
      pos  = t % FRAME;
      slot = pos / SLOT;
      ph   = pos % SLOT;
      e.fs = (pos == 0) && (t > 0);
      if (ph < DC) begin
         e.an  = 4'hF;
         e.seg = 7'h7F;
      end else begin
         e.an       = 4'hF;
         e.an[slot] = 1'b0;
         n     = m_act_d[slot*4 +: 4];
         blank = m_act_m[slot] || (m_act_lz && slot >= 1 && ((m_act_d >> (4*slot)) == 16'h0));
         e.seg = blank ? 7'h7F : segtab[n];
      end
      return e;
   endfunction

   task automatic model_step(input logic ld, input logic [15:0] d,
                             input logic [3:0] m, input logic lz);
      if (rst) begin
         t = 0;
         m_act_d = 16'h0; m_act_m = 4'h0; m_act_lz = 1'b0;
         m_pnd_d = 16'h0; m_pnd_m = 4'h0; m_pnd_lz = 1'b0;
         m_pv = 1'b0;
      end else begin
         t++;
         if ((t % FRAME) == 0 && m_pv) begin
            m_act_d = m_pnd_d; m_act_m = m_pnd_m; m_act_lz = m_pnd_lz;
            m_pv = 1'b0;
         end
         if (ld) begin
            m_pnd_d = d; m_pnd_m = m; m_pnd_lz = lz;
            m_pv = 1'b1;
         end
      end
      sb_q.push_back(expect_now());
   endtask

   task automatic cyc(input logic ld, input logic [15:0] d,
                      input logic [3:0] m, input logic lz);
      bus.load       = ld;
      bus.data       = d;
      bus.blank_mask = m;
      bus.lz_en      = lz;
      @(posedge clk);
      model_step(ld, d, m, lz);
      #1 bus.load = 1'b0;
   endtask

   // idle cycles wiggle the data inputs to show they are ignored without load
   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("an", 32'(bus.an), 32'(e.an));
         chk("seg", 32'(bus.seg), 32'(e.seg));
         chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
         chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
      end
   end

   initial begin
      segtab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      bus.load = 1'b0; bus.data = 16'h0; bus.blank_mask = 4'h0; bus.lz_en = 1'b0;
      m_act_d = 16'h0; m_act_m = 4'h0; m_act_lz = 1'b0;
      m_pnd_d = 16'h0; m_pnd_m = 4'h0; m_pnd_lz = 1'b0; m_pv = 1'b0;

      #1 rst = 1'b1;
      #1;
      chk("rst_an", 32'(bus.an), 32'hF);
      chk("rst_seg", 32'(bus.seg), 32'h7F);
      chk("rst_fs", 32'(bus.frame_start), 32'h0);
      // a load under reset must be ignored
      cyc(1'b1, 16'h9999, 4'h0, 1'b0);
      idle(2);
      @(negedge clk); #1 rst = 1'b0;

      // free-running scan with all-zero content
      idle(30);

      // mid-frame load, visible only from next frame
      cyc(1'b1, 16'h12AF, 4'h0, 1'b0);
      idle(2 * FRAME);

      cyc(1'b1, 16'h0050, 4'h0, 1'b1);
      idle(2 * FRAME);
      cyc(1'b1, 16'h0000, 4'h0, 1'b1);
      idle(2 * FRAME);

      // two loads in one frame: only the last survives
      idle(3);
      cyc(1'b1, 16'hDEAD, 4'h0, 1'b0);
      idle(2);
      cyc(1'b1, 16'hBEEF, 4'h0, 1'b0);
      idle(FRAME);

      // load 1111 mid-frame, then 3333 exactly on the wrap edge
      idle(5);
      cyc(1'b1, 16'h1111, 4'h0, 1'b0);
      for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) idle(1);
      chk("wrap_align", 32'(t % FRAME), 32'(FRAME - 1));
      cyc(1'b1, 16'h3333, 4'h0, 1'b0);
      idle(2 * FRAME + 2);

      cyc(1'b1, 16'h8888, 4'b1010, 1'b0);
      idle(2 * FRAME);

      // random traffic
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 39) == 0)
            cyc(1'b1, 16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         else
            idle(1);
      end

      // pending load then async reset during digit 2 DRIVE
      for (int i = 0; i < FRAME && (t % FRAME) != 1; i++) idle(1);
      cyc(1'b1, 16'h5555, 4'h0, 1'b0);
      for (int i = 0; i < FRAME && (t % FRAME) != 2*SLOT + DC; i++) idle(1);
      chk("drive2_align", 32'(t % FRAME), 32'(2*SLOT + DC));
      @(negedge clk); #1 rst = 1'b1;
      #1;
      chk("arst_an", 32'(bus.an), 32'hF);
      chk("arst_seg", 32'(bus.seg), 32'h7F);
      chk("arst_fs", 32'(bus.frame_start), 32'h0);
      idle(2);
      @(negedge clk); #1 rst = 1'b0;
      idle(2 * FRAME + 3);

      @(negedge clk); #1;
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
